// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch target buffer: entry layout,
// counter encodings and PC index/tag extraction.
package branch_pred_pkg;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [2:0]  ctr;
    } btb_entry_t;

    // Weakly-taken: MSB set, rest clear.
    function automatic logic [2:0] weak_t(input int ctr_w);
        return 3'(1 << (ctr_w - 1));
    endfunction

    // Weakly-not-taken: MSB clear, rest set (0 for a 1-bit counter).
    function automatic logic [2:0] weak_nt(input int ctr_w);
        return 3'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating up/down direction counter, one per BTB entry.
// Priority: load > force_max > inc/dec; resets to weakly-not-taken.
module sat_ctr
    import branch_pred_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             dec,
    input  logic             force_max,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic [CTR_W-1:0] q
);

    localparam logic [CTR_W-1:0] CMAX    = '1;
    localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(weak_nt(CTR_W));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (force_max) begin
            q <= CMAX;
        end else if (inc) begin
            if (q != CMAX) q <= q + CTR_W'(1);
        end else if (dec) begin
            if (q != '0) q <= q - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Zero-latency lookup for fetch; trained by MEM-stage resolution when the pipe advances.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic              upd_taken,
    input  logic              upd_uncond,
    input  logic              upd_mispred,
    input  logic              flush_all,
    output logic [PERF_W-1:0] perf_lookups,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic              valid_q [ENTRIES];
    logic [29:0]       tag_q   [ENTRIES];
    logic [31:0]       tgt_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];
    btb_entry_t        btb     [ENTRIES];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [29:0]       lk_tag, up_tag;
    logic              upd_go, upd_hit;
    logic [CTR_W-1:0]  alloc_ctr;
    btb_entry_t        lk_ent;

    assign lk_idx = IDX_W'(pc_index(lookup_pc, IDX_W));
    assign lk_tag = pc_tag(lookup_pc, IDX_W);
    assign up_idx = IDX_W'(pc_index(upd_pc, IDX_W));
    assign up_tag = pc_tag(upd_pc, IDX_W);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            btb[i].valid  = valid_q[i];
            btb[i].tag    = tag_q[i];
            btb[i].target = tgt_q[i];
            btb[i].ctr    = 3'(ctr_q[i]);
        end
    end

    // Lookup reads registered state only: a same-cycle update is not bypassed.
    assign lk_ent      = btb[lk_idx];
    assign pred_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign pred_taken  = pred_hit && (|(lk_ent.ctr >> (CTR_W - 1)));
    assign pred_target = pred_taken ? lk_ent.target : lookup_pc + 32'd4;

    // flush_all wins over a same-edge update.
    assign upd_go    = en && upd_valid && !flush_all;
    assign upd_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign alloc_ctr = upd_uncond ? '1 : CTR_W'(weak_t(CTR_W));

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = upd_go && (up_idx == IDX_W'(g));
        sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .CLK       (CLK),
            .nRST      (nRST),
            .inc       (sel && upd_hit && upd_taken),
            .dec       (sel && upd_hit && !upd_taken),
            .force_max (sel && upd_hit && upd_uncond),
            .load      (sel && !upd_hit && upd_taken),
            .load_val  (alloc_ctr),
            .q         (ctr_q[g])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (upd_go && upd_taken) begin
            tgt_q[up_idx] <= upd_target;
            if (!upd_hit) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_lookups <= '0;
            perf_mispred <= '0;
        end else begin
            if (en && (perf_lookups != '1))
                perf_lookups <= perf_lookups + PERF_W'(1);
            if (en && upd_valid && upd_mispred && (perf_mispred != '1))
                perf_mispred <= perf_mispred + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed checks of branch_predictor against an array-based BTB model.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        en = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        upd_uncond = 1'b0;
    logic        upd_mispred = 1'b0;
    logic        flush_all = 1'b0;
    logic [31:0] perf_lookups, perf_mispred;
    logic        p4_hit, p4_taken;
    logic [31:0] p4_target;
    logic [3:0]  p4_lookups, p4_mispred;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(16), .CTR_W(2), .PERF_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_uncond(upd_uncond), .upd_mispred(upd_mispred),
        .flush_all(flush_all), .perf_lookups(perf_lookups), .perf_mispred(perf_mispred)
    );

    branch_predictor #(.ENTRIES(16), .CTR_W(2), .PERF_W(4)) dut_p4 (
        .CLK(CLK), .nRST(nRST), .en(en), .lookup_pc(lookup_pc),
        .pred_hit(p4_hit), .pred_taken(p4_taken), .pred_target(p4_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_uncond(upd_uncond), .upd_mispred(upd_mispred),
        .flush_all(flush_all), .perf_lookups(p4_lookups), .perf_mispred(p4_mispred)
    );

    // Reference model: 16 direct-mapped slots, counters as plain integers 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_ctr   [16];
    longint      m_look, m_mis;

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_look = 0; m_mis = 0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic h, output logic t,
                            output logic [31:0] tg);
        int i;
        i  = int'((pc >> 2) % 16);
        h  = m_valid[i] && (m_tag[i] == (pc >> 6));
        t  = h && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_edge();
        int i;
        i = int'((upd_pc >> 2) % 16);
        if (flush_all) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else if (en && upd_valid) begin
            if (m_valid[i] && m_tag[i] == (upd_pc >> 6)) begin
                if (upd_uncond) m_ctr[i] = 3;
                else if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                if (upd_taken) m_tgt[i] = upd_target;
            end else if (upd_taken) begin
                m_valid[i] = 1; m_tag[i] = upd_pc >> 6; m_tgt[i] = upd_target;
                m_ctr[i] = upd_uncond ? 3 : 2;
            end
        end
        if (en) m_look++;
        if (en && upd_valid && upd_mispred) m_mis++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk,
                           input logic unc, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tg;
        upd_taken = tk; upd_uncond = unc; upd_mispred = mis;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        upd_valid = 1'b0; flush_all = 1'b0; en = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        lookup_pc = 32'h40;
        do_reset();
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h44}) begin
            failures++;
            $display("FAIL reset_lookup got hit=%b tk=%b tgt=%h want 0 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
        checks++;
        if ({perf_lookups, perf_mispred} !== 64'd0) begin
            failures++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", perf_lookups, perf_mispred);
        end
    endtask

    task automatic test_train();
        logic eh, et; logic [31:0] etg;
        do_reset();
        en = 1'b1; lookup_pc = 32'h40;
        set_upd(32'h40, 32'h80, 1'b1, 1'b0, 1'b1);
        tick();
        for (int n = 0; n < 3; n++) begin
            upd_valid = 1'b0;
            m_lookup(lookup_pc, eh, et, etg);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== {eh, et, etg}) begin
                failures++;
                $display("FAIL train_step%0d got hit=%b tk=%b tgt=%h want %b %b %h",
                         n, pred_hit, pred_taken, pred_target, eh, et, etg);
            end
            set_upd(32'h40, 32'h80, 1'b0, 1'b0, 1'b1);
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h44}) begin
            failures++;
            $display("FAIL train_final got hit=%b tk=%b tgt=%h want 1 0 00000044",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        logic eh, et; logic [31:0] etg;
        logic [31:0] pcs [4];
        pcs = '{32'h80, 32'h40, 32'h80, 32'h40};
        do_reset();
        en = 1'b1;
        set_upd(32'h40, 32'h90, 1'b1, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 4; n++) begin
            upd_valid = 1'b0;
            lookup_pc = pcs[n];
            #1;
            m_lookup(lookup_pc, eh, et, etg);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== {eh, et, etg}) begin
                failures++;
                $display("FAIL alias_step%0d pc=%h got hit=%b tk=%b tgt=%h want %b %b %h",
                         n, lookup_pc, pred_hit, pred_taken, pred_target, eh, et, etg);
            end
            if (n == 1) begin
                set_upd(32'h80, 32'hA0, 1'b1, 1'b0, 1'b1);
                tick();
            end
        end
    endtask

    task automatic test_uncond();
        logic eh, et; logic [31:0] etg;
        do_reset();
        en = 1'b1; lookup_pc = 32'h100;
        set_upd(32'h100, 32'h200, 1'b1, 1'b1, 1'b0);
        tick();
        for (int n = 0; n < 5; n++) begin
            upd_valid = 1'b0;
            m_lookup(lookup_pc, eh, et, etg);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== {eh, et, etg}) begin
                failures++;
                $display("FAIL uncond_nt%0d got hit=%b tk=%b tgt=%h want %b %b %h",
                         n, pred_hit, pred_taken, pred_target, eh, et, etg);
            end
            set_upd(32'h100, 32'h200, 1'b0, 1'b0, 1'b0);
            tick();
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_en_flush();
        logic eh, et; logic [31:0] etg;
        logic [31:0] pcs [3];
        pcs = '{32'h200, 32'h304, 32'h408};
        do_reset();
        en = 1'b0; lookup_pc = 32'h200;
        set_upd(32'h200, 32'h600, 1'b1, 1'b1, 1'b1);
        tick();
        upd_valid = 1'b0;
        checks++;
        if ({pred_hit, pred_target} !== {1'b0, 32'h204}) begin
            failures++;
            $display("FAIL en_low_update got hit=%b tgt=%h want 0 00000204", pred_hit, pred_target);
        end
        en = 1'b1;
        set_upd(32'h304, 32'h700, 1'b1, 1'b0, 1'b0);
        tick();
        lookup_pc = 32'h304;
        #1;
        checks++;
        if (pred_hit !== 1'b1) begin
            failures++;
            $display("FAIL pre_flush_hit got %b want 1", pred_hit);
        end
        flush_all = 1'b1;
        set_upd(32'h408, 32'h800, 1'b1, 1'b1, 1'b0);
        tick();
        flush_all = 1'b0; upd_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            lookup_pc = pcs[n];
            #1;
            m_lookup(lookup_pc, eh, et, etg);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== {eh, et, etg}) begin
                failures++;
                $display("FAIL flush_pc%0d got hit=%b tk=%b tgt=%h want %b %b %h",
                         n, pred_hit, pred_taken, pred_target, eh, et, etg);
            end
        end
    endtask

    task automatic test_perf();
        do_reset();
        en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n == 2 || n == 5 || n == 7)
                set_upd(32'($urandom_range(0, 255)) << 2, $urandom, 1'($urandom), 1'b0, 1'b1);
            else
                upd_valid = 1'b0;
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if (perf_lookups !== 32'(m_look) || perf_mispred !== 32'(m_mis)) begin
            failures++;
            $display("FAIL perf_ten got %0d/%0d want %0d/%0d",
                     perf_lookups, perf_mispred, m_look, m_mis);
        end
        for (int n = 0; n < 20; n++) begin
            set_upd(32'h40, 32'h80, 1'b1, 1'b0, 1'($urandom));
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if (p4_lookups !== 4'(sat15(m_look)) || p4_mispred !== 4'(sat15(m_mis))) begin
            failures++;
            $display("FAIL perf_sat4 got %0d/%0d want %0d/%0d",
                     p4_lookups, p4_mispred, sat15(m_look), sat15(m_mis));
        end
        checks++;
        if (perf_lookups !== 32'(m_look)) begin
            failures++;
            $display("FAIL perf_thirty got %0d want %0d", perf_lookups, m_look);
        end
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({perf_lookups, perf_mispred, p4_lookups, p4_mispred} !== 72'd0 || pred_hit !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got %0d/%0d/%0d/%0d hit=%b want zeros",
                     perf_lookups, perf_mispred, p4_lookups, p4_mispred, pred_hit);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_random();
        logic eh, et; logic [31:0] etg;
        int errs;
        errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 4) != 0);
            flush_all = ($urandom_range(0, 49) == 0);
            lookup_pc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            upd_uncond = ($urandom_range(0, 5) == 0);
            set_upd((32'($urandom_range(0, 63)) << 2), $urandom & 32'hFFFC,
                    upd_uncond | 1'($urandom), upd_uncond, 1'($urandom));
            upd_valid = ($urandom_range(0, 2) != 0);
            tick();
            m_lookup(lookup_pc, eh, et, etg);
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== {eh, et, etg}) begin
                failures++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_lookup n=%0d pc=%h got %b %b %h want %b %b %h",
                             n, lookup_pc, pred_hit, pred_taken, pred_target, eh, et, etg);
            end
        end
        en = 1'b0; upd_valid = 1'b0; flush_all = 1'b0;
        #1;
        checks++;
        if (perf_lookups !== 32'(m_look) || perf_mispred !== 32'(m_mis)) begin
            failures++;
            $display("FAIL random_perf got %0d/%0d want %0d/%0d",
                     perf_lookups, perf_mispred, m_look, m_mis);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_train();
        test_alias();
        test_uncond();
        test_en_flush();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
